// File: rtl/regfile_write_arbiter.sv
// Write-port owner for registerFile: zero-sweeps the file after reset, then
// grants the single write port to NUM_REQ requesters in round-robin order.
module regfile_write_arbiter #(
  parameter int REG_WIDTH        = 16,
  parameter int REG_ADDR_BITS    = 4,
  parameter int NUM_REQ          = 3,
  parameter int INIT_ON_RESET    = 1,
  parameter int ZERO_REG_PROTECT = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*REG_ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rf_we,
  output logic [REG_ADDR_BITS-1:0]         rf_waddr,
  output logic [REG_WIDTH-1:0]             rf_wdata,
  output logic                             init_done
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {S_INIT, S_ARB} state_t;

  state_t                   state_q, state_d;
  logic [REG_ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                     rf_we_q, rf_we_d;
  logic [REG_ADDR_BITS-1:0] rf_waddr_q, rf_waddr_d;
  logic [REG_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
  logic                     init_done_q, init_done_d;

  logic [REG_ADDR_BITS-1:0] addr_arr [NUM_REQ];
  logic [REG_WIDTH-1:0]     data_arr [NUM_REQ];

  logic                     found;
  logic [PTR_W-1:0]         grant_idx;
  int                       scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*REG_ADDR_BITS +: REG_ADDR_BITS];
      assign data_arr[gi] = req_data[gi*REG_WIDTH +: REG_WIDTH];
    end
  endgenerate

  // Circular scan starting at rr_ptr; the explicit wrap keeps indices legal
  // for non-power-of-2 NUM_REQ.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = PTR_W'(scan_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_ARB && found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    init_done_d = init_done_q;
    case (state_q)
      S_INIT: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = cnt_q;
        rf_wdata_d = '0;
        cnt_d      = cnt_q + REG_ADDR_BITS'(1);
        if (cnt_q == '1) begin
          state_d     = S_ARB;
          init_done_d = 1'b1;
        end
      end
      S_ARB: begin
        init_done_d = 1'b1;
        if (found) begin
          rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
          // A protected r0 write still completes the handshake but never reaches the file.
          if (!((ZERO_REG_PROTECT != 0) && (addr_arr[grant_idx] == '0))) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = addr_arr[grant_idx];
            rf_wdata_d = data_arr[grant_idx];
          end
        end
      end
      default: state_d = S_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (INIT_ON_RESET != 0) ? S_INIT : S_ARB;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: default instance plus a second
// instance with r0 protection and no reset sweep.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [2:0]  req_valid = '0;
  logic [11:0] req_addr  = '0;
  logic [47:0] req_data  = '0;
  logic [2:0]  req_ready;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        init_done;

  logic [2:0]  zp_valid = '0;
  logic [11:0] zp_addr  = '0;
  logic [47:0] zp_data  = '0;
  logic [2:0]  zp_ready;
  logic        zp_we;
  logic [3:0]  zp_waddr;
  logic [15:0] zp_wdata;
  logic        zp_init_done;

  int vectors = 0;
  int miscompares = 0;

  regfile_write_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .init_done(init_done)
  );

  regfile_write_arbiter #(.INIT_ON_RESET(0), .ZERO_REG_PROTECT(1)) u_zp (
    .clk(clk), .rst_n(rst_n),
    .req_valid(zp_valid), .req_addr(zp_addr), .req_data(zp_data),
    .req_ready(zp_ready), .rf_we(zp_we), .rf_waddr(zp_waddr),
    .rf_wdata(zp_wdata), .init_done(zp_init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] d3 [3];

  initial begin
    d3[0] = 16'hA000; d3[1] = 16'hB111; d3[2] = 16'hC222;

    // Reset state
    req_valid = 3'b111;
    #2;
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_init_done", init_done, 0);
    check("rst_ready", req_ready, 0);
    check("zp_rst_init_done", zp_init_done, 0);
    #10 rst_n = 1'b1;

    // Sweep of 16 zero writes; requests ignored until ARB
    for (int i = 0; i < 16; i++) begin
      tick;
      check($sformatf("sweep_we[%0d]", i), rf_we, 1);
      check($sformatf("sweep_waddr[%0d]", i), rf_waddr, i);
      check($sformatf("sweep_wdata[%0d]", i), rf_wdata, 0);
      check($sformatf("sweep_done[%0d]", i), init_done, (i == 15) ? 1 : 0);
      check($sformatf("sweep_ready[%0d]", i), req_ready, (i == 15) ? 3'b001 : 3'b000);
      if (i == 0) begin
        check("zp_init_done_first_edge", zp_init_done, 1);
        check("zp_no_sweep", zp_we, 0);
      end
    end
    req_valid = 3'b000;
    tick;
    check("post_sweep_we", rf_we, 0);
    check("post_sweep_done", init_done, 1);

    // Single requester 1
    req_valid = 3'b010; req_addr[7:4] = 4'd5; req_data[31:16] = 16'hBEEF;
    #1 check("t2_ready", req_ready, 3'b010);
    tick;
    req_valid = 3'b000;
    check("t2_we", rf_we, 1);
    check("t2_waddr", rf_waddr, 5);
    check("t2_wdata", rf_wdata, 16'hBEEF);
    tick;
    check("t2_we_off", rf_we, 0);
    check("t2_waddr_hold", rf_waddr, 5);
    check("t2_wdata_hold", rf_wdata, 16'hBEEF);

    // Requester 2 alone, bringing rr_ptr back to 0
    req_valid = 3'b100; req_addr[11:8] = 4'd3; req_data[47:32] = d3[2];
    #1 check("r2_ready", req_ready, 3'b100);
    tick;
    req_valid = 3'b000;
    check("r2_waddr", rf_waddr, 3);

    // All valid for 6 cycles: 0,1,2,0,1,2
    req_addr = {4'd3, 4'd2, 4'd1};
    req_data = {d3[2], d3[1], d3[0]};
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("t3_ready[%0d]", k), req_ready, 3'b001 << (k % 3));
      tick;
      if (k == 5) req_valid = 3'b000;
      check($sformatf("t3_we[%0d]", k), rf_we, 1);
      check($sformatf("t3_waddr[%0d]", k), rf_waddr, (k % 3) + 1);
      check($sformatf("t3_wdata[%0d]", k), rf_wdata, d3[k % 3]);
    end
    tick;
    check("t3_we_off", rf_we, 0);

    // Grant requester 1 (rr_ptr -> 2), then 3'b101 -> 2 first, then 0
    req_valid = 3'b010;
    tick;
    req_valid = 3'b101;
    #1 check("t4_ready_a", req_ready, 3'b100);
    tick;
    req_valid = 3'b001;
    check("t4_waddr_a", rf_waddr, 3);
    #1 check("t4_ready_b", req_ready, 3'b001);
    tick;
    req_valid = 3'b000;
    check("t4_waddr_b", rf_waddr, 1);
    check("t4_wdata_b", rf_wdata, d3[0]);

    // Protected r0 write: accepted, dropped, pointer still advances
    zp_valid = 3'b001; zp_addr = {4'd7, 4'd9, 4'd0}; zp_data = {16'h7777, 16'h5555, 16'h1234};
    #1 check("t5_ready0", zp_ready, 3'b001);
    tick;
    zp_valid = 3'b011;
    check("t5_we_dropped", zp_we, 0);
    check("t5_waddr_hold", zp_waddr, 0);
    check("t5_wdata_hold", zp_wdata, 0);
    #1 check("t5_ready1", zp_ready, 3'b010);
    tick;
    zp_valid = 3'b000;
    check("t5_we1", zp_we, 1);
    check("t5_waddr1", zp_waddr, 9);
    check("t5_wdata1", zp_wdata, 16'h5555);

    // Reset mid-sweep at cnt=7, then full restart
    rst_n = 1'b0;
    #10 rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick;
    check("t6_pre_waddr", rf_waddr, 6);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_we", rf_we, 0);
    check("t6_async_waddr", rf_waddr, 0);
    check("t6_async_done", init_done, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick;
      check($sformatf("t6_we[%0d]", i), rf_we, 1);
      check($sformatf("t6_waddr[%0d]", i), rf_waddr, i);
    end
    check("t6_done", init_done, 1);
    tick;
    check("t6_we_off", rf_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
